mem_port_router: RTL and testbench
==================================

Name: mem_port_router

Overview:
- Shares one single-ported unified memory between the instruction-fetch requester (I) and the load/store requester (D) of the femtoRV32 core.
- Forward path: arbitrates requests onto the memory port.
- Return path: demultiplexes in-order read responses back to whichever requester issued each read.
- Sits between the IF/MEM pipeline stages and the memory model.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; byte enables are DATA_W/8 wide
MAX_OUT, 2, max outstanding reads tracked (legal range 1..4)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
i_req_valid  in  1  fetch request valid
i_req_ready  out  1  fetch request accepted this cycle
i_req_addr  in  ADDR_W  fetch address
i_flush  in  1  discard all outstanding fetch responses (branch taken)
i_rsp_valid  out  1  fetch data valid (1-cycle pulse)
i_rsp_data  out  DATA_W  fetch data
d_req_valid  in  1  data request valid
d_req_ready  out  1  data request accepted this cycle
d_req_addr  in  ADDR_W  data address
d_req_we  in  1  1 = store, 0 = load
d_req_wdata  in  DATA_W  store data
d_req_be  in  DATA_W/8  store byte enables
d_rsp_valid  out  1  load data valid (1-cycle pulse)
d_rsp_data  out  DATA_W  load data
m_req_valid  out  1  memory request valid
m_req_ready  in  1  memory accepts request
m_req_addr  out  ADDR_W  memory address
m_req_we  out  1  memory write enable
m_req_wdata  out  DATA_W  memory write data
m_req_be  out  DATA_W/8  memory byte enables
m_rsp_valid  in  1  memory read data valid; reads only, in order
m_rsp_data  in  DATA_W  memory read data
err_orphan  out  1  sticky: a response arrived with no outstanding read

Behaviour:
Interface (decided):
- Single clock, clk.
- Reset rst_n is synchronous and active-low.
- Reset: all outputs registered or derived are 0. Tag FIFO is emptied, outstanding count is 0, err_orphan is 0.

Request path (combinational from inputs plus state):
- can_acc = (count < MAX_OUT) | pop_this_cycle.
- Stores do not need a slot: a D store ignores can_acc.
- Fixed priority: D wins over I, because the older instruction must not deadlock.
- m_req_valid = can_go_D | can_go_I.
- Address, we, wdata and be are muxed from the winner. When I wins: we = 0 and be = all 1s.
- d_req_ready = m_req_ready & d_req_valid & (d_req_we | can_acc).
- i_req_ready = m_req_ready & i_req_valid & can_acc & ~d_req_valid.
- A request is accepted on a cycle with valid & ready. The requester must hold its valid and payload until accepted.

Tracking:
- Each accepted read pushes {drop=0, tag} into the tag FIFO; tag I = 0, D = 1.
- An accepted store pushes nothing.

Response path (registered, latency 1):
- On m_rsp_valid with FIFO non-empty: pop the head.
- If tag = D: next cycle d_rsp_valid = 1 and d_rsp_data = m_rsp_data.
- If tag = I and drop = 0: next cycle i_rsp_valid = 1 and i_rsp_data = m_rsp_data.
- If tag = I and drop = 1: the response is consumed silently.
- Data outputs hold their last value when valid = 0.

Flush:
- i_flush sets drop on every FIFO entry with tag I, including the head being popped in the same cycle. That response is suppressed.
- A fetch accepted in the same cycle as i_flush is NOT marked drop.
- D entries are unaffected by flush.

Counter:
- count updates on push only (+1), pop only (−1), and is unchanged on simultaneous push and pop.
- A push when full is allowed only together with a pop.

Orphan:
- m_rsp_valid with FIFO empty: the response is dropped, no rsp_valid is raised, and err_orphan is set to 1.
- err_orphan is cleared only by reset.

Reset mid-operation:
- Outstanding entries are discarded.
- Responses arriving after reset are orphans.

Decomposition:
- Package femto_mem_pkg: TAG_I = 1'b0, TAG_D = 1'b1; default ADDR_W and DATA_W constants; the tag-entry struct/width {drop, tag}.
- Sub-module tag_fifo:
  - Synchronous FIFO of depth MAX_OUT with push, pop, full, empty and head.
  - Provides a flush-mark input that sets drop on all I entries.

Test Plan:
1. Reset, then I read 0x100 and memory returns 0xDEADBEEF one cycle later -> i_rsp_valid for 1 cycle with 0xDEADBEEF; d_rsp_valid stays 0.
2. I and D reads both valid in the same cycle (D addr 0x200) -> D accepted first and i_req_ready = 0. Next cycle I is accepted. Responses 0x11, 0x22 -> d_rsp gets 0x11, then i_rsp gets 0x22.
3. MAX_OUT = 2: two reads outstanding and a third I read waiting -> i_req_ready = 0 until the cycle with m_rsp_valid, when it is accepted with the pop; count stays 2.
4. D store 0x300 / 0xCAFEF00D / be = 0011 while two reads are outstanding -> accepted immediately; m_req_we = 1 with the wdata/be passed through; the FIFO is unchanged.
5. Two I reads outstanding, i_flush asserted in the same cycle a new I read is accepted, responses 0xA, 0xB, 0xC -> only 0xC appears on i_rsp.
6. m_rsp_valid with no outstanding reads -> no rsp_valid and err_orphan = 1. rst_n = 0 for one cycle -> err_orphan = 0.

Source files
------------

// File: rtl/mem_port_router_pkg.sv
// Shared types and constants for the femtoRV32 unified-memory port router.
// A tag entry records which requester owns an outstanding read and whether a flush voided it.
package femto_mem_pkg;

  localparam logic TAG_I = 1'b0;
  localparam logic TAG_D = 1'b1;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef struct packed {
    logic drop;
    logic tag;
  } tag_entry_t;

  localparam int TAG_ENTRY_W = $bits(tag_entry_t);

endpackage

// File: rtl/mem_port_router_tag_fifo.sv
// In-order FIFO of outstanding-read tags; a flush mark voids every fetch entry in place.
// Push is honoured when not full, or when full together with a pop.
module tag_fifo
  import femto_mem_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_push,
  input  tag_entry_t i_push_entry,
  input  logic       i_pop,
  input  logic       i_flush_mark,
  output logic       o_full,
  output logic       o_empty,
  output tag_entry_t o_head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  tag_entry_t       r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign o_full  = (r_count == DEPTH_CNT);
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
    end else begin
      // Marking idle slots is harmless: a push always writes drop = 0.
      for (int k = 0; k < DEPTH; k++) begin
        if (i_flush_mark && (r_mem[k].tag == TAG_I)) r_mem[k].drop <= 1'b1;
      end
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_entry;
        r_wr_ptr        <= next_ptr(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mem_port_router.sv
// Routes fetch (I) and load/store (D) requests onto one memory port with D priority,
// and steers in-order read responses back to their owner one cycle later.
module mem_port_router
  import femto_mem_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MAX_OUT = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_req_valid,
  output logic                i_req_ready,
  input  logic [ADDR_W-1:0]   i_req_addr,
  input  logic                i_flush,
  output logic                i_rsp_valid,
  output logic [DATA_W-1:0]   i_rsp_data,
  input  logic                d_req_valid,
  output logic                d_req_ready,
  input  logic [ADDR_W-1:0]   d_req_addr,
  input  logic                d_req_we,
  input  logic [DATA_W-1:0]   d_req_wdata,
  input  logic [DATA_W/8-1:0] d_req_be,
  output logic                d_rsp_valid,
  output logic [DATA_W-1:0]   d_rsp_data,
  output logic                m_req_valid,
  input  logic                m_req_ready,
  output logic [ADDR_W-1:0]   m_req_addr,
  output logic                m_req_we,
  output logic [DATA_W-1:0]   m_req_wdata,
  output logic [DATA_W/8-1:0] m_req_be,
  input  logic                m_rsp_valid,
  input  logic [DATA_W-1:0]   m_rsp_data,
  output logic                err_orphan
);

  // Handshake: a request transfers on a cycle where its valid and ready are both high;
  // the requester holds valid and payload stable until then. Responses are 1-cycle pulses.

  logic              w_fifo_full;
  logic              w_fifo_empty;
  tag_entry_t        w_head;
  tag_entry_t        w_push_entry;
  logic              w_pop;
  logic              w_push;
  logic              w_can_acc;
  logic              w_go_d;
  logic              w_go_i;
  logic              w_head_drop;
  logic              w_deliver_i;
  logic              w_deliver_d;

  logic              r_i_rsp_valid;
  logic [DATA_W-1:0] r_i_rsp_data;
  logic              r_d_rsp_valid;
  logic [DATA_W-1:0] r_d_rsp_data;
  logic              r_err_orphan;

  assign w_pop     = m_rsp_valid & ~w_fifo_empty;
  assign w_can_acc = ~w_fifo_full | w_pop;

  // Stores get no response, so they never need a tracking slot.
  assign w_go_d = rst_n & d_req_valid & (d_req_we | w_can_acc);
  assign w_go_i = rst_n & i_req_valid & ~d_req_valid & w_can_acc;

  assign m_req_valid = w_go_d | w_go_i;
  assign d_req_ready = m_req_ready & w_go_d;
  assign i_req_ready = m_req_ready & w_go_i;

  always_comb begin
    m_req_addr  = '0;
    m_req_we    = 1'b0;
    m_req_wdata = '0;
    m_req_be    = '0;
    if (w_go_d) begin
      m_req_addr  = d_req_addr;
      m_req_we    = d_req_we;
      m_req_wdata = d_req_wdata;
      m_req_be    = d_req_be;
    end else if (w_go_i) begin
      m_req_addr  = i_req_addr;
      m_req_be    = '1;
    end
  end

  assign w_push            = (d_req_ready & ~d_req_we) | i_req_ready;
  assign w_push_entry.drop = 1'b0;
  assign w_push_entry.tag  = d_req_ready ? TAG_D : TAG_I;

  tag_fifo #(
    .DEPTH (MAX_OUT)
  ) u_tag_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .i_flush_mark (i_flush),
    .o_full       (w_fifo_full),
    .o_empty      (w_fifo_empty),
    .o_head       (w_head)
  );

  // A flush in the pop cycle still voids the head, since the marking only lands next edge.
  assign w_head_drop = w_head.drop | (i_flush & (w_head.tag == TAG_I));
  assign w_deliver_i = w_pop & (w_head.tag == TAG_I) & ~w_head_drop;
  assign w_deliver_d = w_pop & (w_head.tag == TAG_D);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_i_rsp_valid <= 1'b0;
      r_i_rsp_data  <= '0;
      r_d_rsp_valid <= 1'b0;
      r_d_rsp_data  <= '0;
      r_err_orphan  <= 1'b0;
    end else begin
      r_i_rsp_valid <= w_deliver_i;
      r_d_rsp_valid <= w_deliver_d;
      if (w_deliver_i) r_i_rsp_data <= m_rsp_data;
      if (w_deliver_d) r_d_rsp_data <= m_rsp_data;
      if (m_rsp_valid && w_fifo_empty) r_err_orphan <= 1'b1;
    end
  end

  assign i_rsp_valid = r_i_rsp_valid;
  assign i_rsp_data  = r_i_rsp_data;
  assign d_rsp_valid = r_d_rsp_valid;
  assign d_rsp_data  = r_d_rsp_data;
  assign err_orphan  = r_err_orphan;

endmodule

// File: tb/tb_mem_port_router.sv
// Bench for mem_port_router: request-path vector table, directed multi-cycle sequences,
// and a randomized run checked against an outstanding-read queue model.
module tb_mem_port_router;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int MAX_OUT = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                i_req_valid, i_req_ready, i_flush, i_rsp_valid;
  logic [ADDR_W-1:0]   i_req_addr;
  logic [DATA_W-1:0]   i_rsp_data;
  logic                d_req_valid, d_req_ready, d_req_we, d_rsp_valid;
  logic [ADDR_W-1:0]   d_req_addr;
  logic [DATA_W-1:0]   d_req_wdata, d_rsp_data;
  logic [DATA_W/8-1:0] d_req_be, m_req_be;
  logic                m_req_valid, m_req_ready, m_req_we, m_rsp_valid, err_orphan;
  logic [ADDR_W-1:0]   m_req_addr;
  logic [DATA_W-1:0]   m_req_wdata, m_rsp_data;

  mem_port_router #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_flush(i_flush), .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_we(d_req_we), .d_req_wdata(d_req_wdata), .d_req_be(d_req_be),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_addr(m_req_addr),
    .m_req_we(m_req_we), .m_req_wdata(m_req_wdata), .m_req_be(m_req_be),
    .m_rsp_valid(m_rsp_valid), .m_rsp_data(m_rsp_data), .err_orphan(err_orphan)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_req_valid = 1'b0; i_req_addr = '0; i_flush = 1'b0;
    d_req_valid = 1'b0; d_req_addr = '0; d_req_we = 1'b0; d_req_wdata = '0; d_req_be = '0;
    m_req_ready = 1'b1; m_rsp_valid = 1'b0; m_rsp_data = '0;
  endtask

  task automatic reset_dut();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- request-path vector table ----------------
  // in  = {full, d_valid, d_we, i_valid, m_ready, m_rsp_valid}
  // exp = {m_req_valid, d_req_ready, i_req_ready, m_req_we}
  typedef struct {
    logic [5:0]  in;
    logic [3:0]  exp;
    logic [31:0] addr;
    logic [3:0]  be;
  } vec_t;

  vec_t vecs [12];

  task automatic run_table(input logic phase);
    for (int k = 0; k < 12; k++) begin
      if (vecs[k].in[5] == phase) begin
        d_req_valid = vecs[k].in[4];
        d_req_we    = vecs[k].in[3];
        i_req_valid = vecs[k].in[2];
        m_req_ready = vecs[k].in[1];
        m_rsp_valid = vecs[k].in[0];
        d_req_addr  = 32'h200; d_req_be = 4'hC; d_req_wdata = 32'h1234_5678;
        i_req_addr  = 32'h100;
        #1;
        chk($sformatf("tbl%0d_m_valid", k), m_req_valid, vecs[k].exp[3]);
        chk($sformatf("tbl%0d_d_ready", k), d_req_ready, vecs[k].exp[2]);
        chk($sformatf("tbl%0d_i_ready", k), i_req_ready, vecs[k].exp[1]);
        if (vecs[k].exp[3]) begin
          chk($sformatf("tbl%0d_we", k),   m_req_we,   vecs[k].exp[0]);
          chk($sformatf("tbl%0d_addr", k), m_req_addr, vecs[k].addr);
          chk($sformatf("tbl%0d_be", k),   m_req_be,   vecs[k].be);
        end
        clear_inputs();
        #1;
      end
    end
  endtask

  // ---------------- reference model for random run ----------------
  typedef struct {
    logic is_d;
    logic drop;
  } ent_t;

  ent_t              exp_q[$];
  logic              exp_iv, exp_dv, exp_err;
  logic [DATA_W-1:0] exp_id, exp_dd;

  task automatic random_run(input int cycles);
    logic              d_pend, i_pend, pop, room, e_dgo, e_igo;
    ent_t              head;
    d_pend = 1'b0; i_pend = 1'b0;
    exp_q.delete();
    exp_iv = 1'b0; exp_dv = 1'b0; exp_err = 1'b0; exp_id = '0; exp_dd = '0;
    for (int c = 0; c < cycles; c++) begin
      chk("rnd_i_rsp_valid", i_rsp_valid, exp_iv);
      chk("rnd_i_rsp_data",  i_rsp_data,  exp_id);
      chk("rnd_d_rsp_valid", d_rsp_valid, exp_dv);
      chk("rnd_d_rsp_data",  d_rsp_data,  exp_dd);
      chk("rnd_err_orphan",  err_orphan,  exp_err);
      if (!d_pend && ($urandom_range(0, 2) == 0)) begin
        d_pend = 1'b1; d_req_addr = $urandom; d_req_we = 1'($urandom_range(0, 1));
        d_req_wdata = $urandom; d_req_be = 4'($urandom_range(0, 15));
      end
      if (!i_pend && ($urandom_range(0, 1) == 0)) begin
        i_pend = 1'b1; i_req_addr = $urandom;
      end
      d_req_valid = d_pend;
      i_req_valid = i_pend;
      m_req_ready = ($urandom_range(0, 3) != 0);
      m_rsp_valid = (exp_q.size() > 0) && ($urandom_range(0, 1) == 1);
      m_rsp_data  = $urandom;
      i_flush     = ($urandom_range(0, 7) == 0);
      #1;
      pop   = m_rsp_valid && (exp_q.size() > 0);
      room  = (exp_q.size() < MAX_OUT) || pop;
      e_dgo = d_pend && (d_req_we || room);
      e_igo = i_pend && !d_pend && room;
      chk("rnd_m_valid", m_req_valid, e_dgo || e_igo);
      chk("rnd_d_ready", d_req_ready, e_dgo && m_req_ready);
      chk("rnd_i_ready", i_req_ready, e_igo && m_req_ready);
      if (e_dgo) begin
        chk("rnd_addr_d",  m_req_addr,  d_req_addr);
        chk("rnd_we_d",    m_req_we,    d_req_we);
        chk("rnd_wdata_d", m_req_wdata, d_req_wdata);
        chk("rnd_be_d",    m_req_be,    d_req_be);
      end else if (e_igo) begin
        chk("rnd_addr_i", m_req_addr, i_req_addr);
        chk("rnd_we_i",   m_req_we,   1'b0);
        chk("rnd_be_i",   m_req_be,   4'hF);
      end
      exp_iv = 1'b0;
      exp_dv = 1'b0;
      if (pop) begin
        head = exp_q.pop_front();
        if (head.is_d) begin
          exp_dv = 1'b1; exp_dd = m_rsp_data;
        end else if (!head.drop && !i_flush) begin
          exp_iv = 1'b1; exp_id = m_rsp_data;
        end
      end
      if (i_flush) foreach (exp_q[k]) if (!exp_q[k].is_d) exp_q[k].drop = 1'b1;
      if (e_dgo && m_req_ready) begin
        if (!d_req_we) exp_q.push_back('{is_d: 1'b1, drop: 1'b0});
        d_pend = 1'b0;
      end else if (e_igo && m_req_ready) begin
        exp_q.push_back('{is_d: 1'b0, drop: 1'b0});
        i_pend = 1'b0;
      end
      tick();
    end
    chk("rnd_final_i_rsp_valid", i_rsp_valid, exp_iv);
    chk("rnd_final_d_rsp_valid", d_rsp_valid, exp_dv);
    chk("rnd_final_err_orphan",  err_orphan,  exp_err);
    clear_inputs();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vecs[0]  = '{6'b010010, 4'b1100, 32'h200, 4'hC};
    vecs[1]  = '{6'b011110, 4'b1101, 32'h200, 4'hC};
    vecs[2]  = '{6'b000110, 4'b1010, 32'h100, 4'hF};
    vecs[3]  = '{6'b000100, 4'b1000, 32'h100, 4'hF};
    vecs[4]  = '{6'b010100, 4'b1000, 32'h200, 4'hC};
    vecs[5]  = '{6'b000010, 4'b0000, 32'h000, 4'h0};
    vecs[6]  = '{6'b110010, 4'b0000, 32'h000, 4'h0};
    vecs[7]  = '{6'b111110, 4'b1101, 32'h200, 4'hC};
    vecs[8]  = '{6'b100110, 4'b0000, 32'h000, 4'h0};
    vecs[9]  = '{6'b110110, 4'b0000, 32'h000, 4'h0};
    vecs[10] = '{6'b100111, 4'b1010, 32'h100, 4'hF};
    vecs[11] = '{6'b110111, 4'b1100, 32'h200, 4'hC};

    clear_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    // reset state, including a request presented while reset is held
    chk("rst_i_rsp_valid", i_rsp_valid, 1'b0);
    chk("rst_d_rsp_valid", d_rsp_valid, 1'b0);
    chk("rst_err_orphan",  err_orphan,  1'b0);
    i_req_valid = 1'b1; i_req_addr = 32'h40;
    #1;
    chk("rst_m_req_valid", m_req_valid, 1'b0);
    chk("rst_i_req_ready", i_req_ready, 1'b0);
    i_req_valid = 1'b0;
    rst_n = 1'b1;

    // table: empty then full
    run_table(1'b0);
    i_req_valid = 1'b1; i_req_addr = 32'h100;
    tick();
    tick();
    i_req_valid = 1'b0;
    run_table(1'b1);

    // 1: single fetch
    reset_dut();
    i_req_valid = 1'b1; i_req_addr = 32'h100;
    #2;
    chk("t1_i_ready", i_req_ready, 1'b1);
    chk("t1_addr",    m_req_addr,  32'h100);
    tick();
    i_req_valid = 1'b0; m_rsp_valid = 1'b1; m_rsp_data = 32'hDEADBEEF;
    #2;
    chk("t1_no_early_rsp", i_rsp_valid, 1'b0);
    tick();
    m_rsp_valid = 1'b0;
    chk("t1_i_rsp_valid", i_rsp_valid, 1'b1);
    chk("t1_i_rsp_data",  i_rsp_data,  32'hDEADBEEF);
    chk("t1_d_rsp_valid", d_rsp_valid, 1'b0);
    tick();
    chk("t1_pulse_end", i_rsp_valid, 1'b0);
    chk("t1_data_hold", i_rsp_data,  32'hDEADBEEF);

    // 2: D beats I, responses return in order
    d_req_valid = 1'b1; d_req_addr = 32'h200; i_req_valid = 1'b1; i_req_addr = 32'h120;
    #2;
    chk("t2_d_ready", d_req_ready, 1'b1);
    chk("t2_i_ready", i_req_ready, 1'b0);
    chk("t2_addr",    m_req_addr,  32'h200);
    tick();
    d_req_valid = 1'b0;
    #2;
    chk("t2_i_ready_next", i_req_ready, 1'b1);
    chk("t2_addr_next",    m_req_addr,  32'h120);
    tick();
    i_req_valid = 1'b0; m_rsp_valid = 1'b1; m_rsp_data = 32'h11;
    tick();
    m_rsp_data = 32'h22;
    chk("t2_d_rsp_valid", d_rsp_valid, 1'b1);
    chk("t2_d_rsp_data",  d_rsp_data,  32'h11);
    chk("t2_i_rsp_quiet", i_rsp_valid, 1'b0);
    tick();
    m_rsp_valid = 1'b0;
    chk("t2_i_rsp_valid", i_rsp_valid, 1'b1);
    chk("t2_i_rsp_data",  i_rsp_data,  32'h22);
    chk("t2_d_rsp_quiet", d_rsp_valid, 1'b0);

    // 3: full, third fetch accepted only alongside a pop
    i_req_valid = 1'b1; i_req_addr = 32'h130;
    tick();
    i_req_valid = 1'b0; d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'h210;
    tick();
    d_req_valid = 1'b0; i_req_valid = 1'b1; i_req_addr = 32'h140;
    #2;
    chk("t3_blocked_a", i_req_ready, 1'b0);
    tick();
    chk("t3_blocked_b", i_req_ready, 1'b0);
    m_rsp_valid = 1'b1; m_rsp_data = 32'h33;
    #2;
    chk("t3_accept_with_pop", i_req_ready, 1'b1);
    tick();
    m_rsp_valid = 1'b0; i_req_valid = 1'b0;
    chk("t3_i_rsp_valid", i_rsp_valid, 1'b1);
    chk("t3_i_rsp_data",  i_rsp_data,  32'h33);
    i_req_valid = 1'b1; i_req_addr = 32'h150;
    #2;
    chk("t3_still_full", i_req_ready, 1'b0);
    i_req_valid = 1'b0;

    // 4: store while full passes straight through
    d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 32'h300;
    d_req_wdata = 32'hCAFEF00D; d_req_be = 4'b0011;
    #2;
    chk("t4_d_ready", d_req_ready, 1'b1);
    chk("t4_we",      m_req_we,    1'b1);
    chk("t4_addr",    m_req_addr,  32'h300);
    chk("t4_wdata",   m_req_wdata, 32'hCAFEF00D);
    chk("t4_be",      m_req_be,    4'b0011);
    tick();
    d_req_valid = 1'b0; d_req_we = 1'b0; i_req_valid = 1'b1;
    #2;
    chk("t4_fifo_unchanged", i_req_ready, 1'b0);
    i_req_valid = 1'b0; m_rsp_valid = 1'b1; m_rsp_data = 32'h44;
    tick();
    m_rsp_data = 32'h55;
    chk("t4_d_rsp_valid", d_rsp_valid, 1'b1);
    chk("t4_d_rsp_data",  d_rsp_data,  32'h44);
    chk("t4_i_rsp_quiet", i_rsp_valid, 1'b0);
    tick();
    m_rsp_valid = 1'b0;
    chk("t4_i_rsp_valid", i_rsp_valid, 1'b1);
    chk("t4_i_rsp_data",  i_rsp_data,  32'h55);
    tick();

    // 5: flush voids older fetches (including the head popped now), not the new one
    i_req_valid = 1'b1; i_req_addr = 32'h160;
    tick();
    i_req_addr = 32'h170;
    tick();
    i_req_addr = 32'h180; i_flush = 1'b1; m_rsp_valid = 1'b1; m_rsp_data = 32'hA;
    #2;
    chk("t5_accept_on_flush", i_req_ready, 1'b1);
    tick();
    i_req_valid = 1'b0; i_flush = 1'b0; m_rsp_data = 32'hB;
    chk("t5_a_dropped", i_rsp_valid, 1'b0);
    tick();
    m_rsp_data = 32'hC;
    chk("t5_b_dropped", i_rsp_valid, 1'b0);
    tick();
    m_rsp_valid = 1'b0;
    chk("t5_c_valid", i_rsp_valid, 1'b1);
    chk("t5_c_data",  i_rsp_data,  32'hC);
    tick();
    chk("t5_end_quiet", i_rsp_valid, 1'b0);
    chk("t5_no_orphan", err_orphan,  1'b0);

    // 6: orphan response, sticky until reset; reset discards outstanding reads
    m_rsp_valid = 1'b1; m_rsp_data = 32'h77;
    tick();
    m_rsp_valid = 1'b0;
    chk("t6_err_set",   err_orphan,  1'b1);
    chk("t6_no_i_rsp",  i_rsp_valid, 1'b0);
    chk("t6_no_d_rsp",  d_rsp_valid, 1'b0);
    tick();
    chk("t6_err_sticky", err_orphan, 1'b1);
    i_req_valid = 1'b1; i_req_addr = 32'h190;
    tick();
    i_req_valid = 1'b0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t6_err_cleared", err_orphan, 1'b0);
    m_rsp_valid = 1'b1; m_rsp_data = 32'h88;
    tick();
    m_rsp_valid = 1'b0;
    chk("t6_post_reset_orphan", err_orphan,  1'b1);
    chk("t6_post_reset_no_rsp", i_rsp_valid, 1'b0);

    // randomized traffic against the queue model
    reset_dut();
    random_run(600);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
